// File: rtl/i2c_slave.sv
// I2C target with 2-FF synchronizers, glitch filters, clock stretching on reads
// and a byte-wide streaming interface for received and transmitted data.
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       scl_pad_i,
    output logic       scl_pad_o,
    output logic       scl_padoen_o,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o,
    output logic       rw_o
);

    localparam int unsigned CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WR_ACK,
        READ,
        RD_ACK
    } state_t;

    logic          scl_s1, scl_s2, sda_s1, sda_s2;
    logic          scl_f, sda_f, scl_prev, sda_prev;
    logic [CW-1:0] scl_cnt, sda_cnt;
    logic          scl_rise, scl_fall, start_det, stop_det;

    state_t      state, state_d;
    logic [3:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  shreg, shreg_d;
    logic        ack_phase, ack_phase_d;
    logic        load_req, load_req_d;
    logic        sda_oen_d, scl_oen_d;
    logic [7:0]  rx_data_d;
    logic        rx_valid_d, busy_d, rw_d;

    assign scl_pad_o = 1'b0;
    assign sda_pad_o = 1'b0;

    // A level change is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            scl_s1   <= scl_pad_i;
            scl_s2   <= scl_s1;
            sda_s1   <= sda_pad_i;
            sda_s2   <= sda_s1;
            scl_prev <= scl_f;
            sda_prev <= sda_f;
            if (scl_s2 == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CNT_MAX) begin
                scl_f   <= scl_s2;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_s2 == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CNT_MAX) begin
                sda_f   <= sda_s2;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    assign scl_rise  = scl_f & ~scl_prev;
    assign scl_fall  = ~scl_f & scl_prev;
    assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

    // The handshake completes in the cycle the pending load sees valid data.
    assign tx_ready_o = (state == READ) && load_req && tx_valid_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            ack_phase    <= 1'b0;
            load_req     <= 1'b0;
            sda_padoen_o <= 1'b1;
            scl_padoen_o <= 1'b1;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            busy_o       <= 1'b0;
            rw_o         <= 1'b0;
            start_o      <= 1'b0;
            stop_o       <= 1'b0;
        end else begin
            state        <= state_d;
            bit_cnt      <= bit_cnt_d;
            shreg        <= shreg_d;
            ack_phase    <= ack_phase_d;
            load_req     <= load_req_d;
            sda_padoen_o <= sda_oen_d;
            scl_padoen_o <= scl_oen_d;
            rx_data_o    <= rx_data_d;
            rx_valid_o   <= rx_valid_d;
            busy_o       <= busy_d;
            rw_o         <= rw_d;
            start_o      <= start_det;
            stop_o       <= stop_det;
        end
    end

    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;
        ack_phase_d = ack_phase;
        load_req_d  = load_req;
        sda_oen_d   = sda_padoen_o;
        scl_oen_d   = 1'b1;
        rx_data_d   = rx_data_o;
        rx_valid_d  = 1'b0;
        busy_d      = busy_o;
        rw_d        = rw_o;

        if (stop_det) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            sda_oen_d   = 1'b1;
            load_req_d  = 1'b0;
            bit_cnt_d   = '0;
            ack_phase_d = 1'b0;
        end else if (start_det) begin
            state_d     = ADDR;
            sda_oen_d   = 1'b1;
            load_req_d  = 1'b0;
            bit_cnt_d   = '0;
            ack_phase_d = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg[6:0], sda_f};
                        bit_cnt_d = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_d = '0;
                            if (shreg[6:0] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = sda_f;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                // First falling edge starts the ACK drive, the second one ends it.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase_d = 1'b1;
                            sda_oen_d   = 1'b0;
                        end else begin
                            ack_phase_d = 1'b0;
                            sda_oen_d   = 1'b1;
                            bit_cnt_d   = '0;
                            if (state == WR_ACK || !rw_o) begin
                                state_d = WRITE;
                            end else begin
                                state_d    = READ;
                                load_req_d = 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg[6:0], sda_f};
                        bit_cnt_d = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rx_data_d  = {shreg[6:0], sda_f};
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = '0;
                            state_d    = WR_ACK;
                        end
                    end
                end
                READ: begin
                    if (load_req) begin
                        if (tx_valid_i) begin
                            shreg_d    = tx_data_i;
                            sda_oen_d  = tx_data_i[7];
                            load_req_d = 1'b0;
                        end else begin
                            scl_oen_d = 1'b0;
                        end
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oen_d   = 1'b1;
                            bit_cnt_d   = '0;
                            ack_phase_d = 1'b0;
                            state_d     = RD_ACK;
                        end else begin
                            shreg_d   = {shreg[6:0], 1'b0};
                            sda_oen_d = shreg[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_f) begin
                            state_d = IDLE;
                        end else begin
                            ack_phase_d = 1'b1;
                        end
                    end else if (scl_fall && ack_phase) begin
                        ack_phase_d = 1'b0;
                        load_req_d  = 1'b1;
                        state_d     = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
